// File: rtl/loss_array.sv
// rtl/loss_array.sv - N-column MSE/MAE gradient stage with squared-error accumulator
// Two register stages per column: capture diff/mode/scale, then scale to gradient.
module loss_array #(
  parameter int NUM_COLS = 2,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40,
  parameter int CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_COLS*DATA_W-1:0]   H_in,
  input  logic [NUM_COLS*DATA_W-1:0]   Y_in,
  input  logic [NUM_COLS-1:0]          valid_in,
  input  logic                         mode_in,
  input  logic [DATA_W-1:0]            inv_batch_size_times_two_in,
  input  logic                         loss_clear_in,
  output logic [NUM_COLS*DATA_W-1:0]   gradient_out,
  output logic [NUM_COLS-1:0]          valid_out,
  output logic [ACC_W-1:0]             loss_sum_out,
  output logic [CNT_W-1:0]             sample_count_out
);

  localparam int DW1   = DATA_W + 1;
  localparam int PW    = 2 * DATA_W + 1;
  localparam int SQW   = 2 * DW1;
  localparam int PCW   = $clog2(NUM_COLS + 1);
  localparam int SUM_W = ACC_W + PCW + 1;
  localparam int CSW   = CNT_W + PCW;

  localparam logic signed [PW-1:0]     G_MAX  = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0]     G_MIN  = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     RND_P  = PW'(1) << (FRAC_W - 1);
  localparam logic [SQW-1:0]           RND_SQ = SQW'(1) << (FRAC_W - 1);
  localparam logic signed [DATA_W-1:0] D_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [NUM_COLS-1:0]     v1_q, v2_q;
  logic [NUM_COLS*SQW-1:0] sq_flat;
  logic [SUM_W-1:0]        sq_sum, acc_sum;
  logic [PCW-1:0]          pop;
  logic [CSW-1:0]          cnt_sum;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic signed [DATA_W-1:0] h, y, scale_q, grad_q, grad_d, half;
    logic signed [DW1-1:0]    diff_d, diff_q;
    logic                     mode_q;
    logic signed [PW-1:0]     prod, prod_sh;
    logic signed [SQW-1:0]    sqp;

    assign h       = H_in[c*DATA_W +: DATA_W];
    assign y       = Y_in[c*DATA_W +: DATA_W];
    assign diff_d  = DW1'(h) - DW1'(y);
    assign prod    = PW'(diff_q) * PW'(scale_q);
    assign prod_sh = (prod + RND_P) >>> FRAC_W;
    assign half    = scale_q >>> 1;
    assign sqp     = SQW'(diff_q) * SQW'(diff_q);
    assign sq_flat[c*SQW +: SQW] = ($unsigned(sqp) + RND_SQ) >> FRAC_W;
    assign gradient_out[c*DATA_W +: DATA_W] = grad_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        diff_q  <= '0;
        mode_q  <= 1'b0;
        scale_q <= '0;
        grad_q  <= '0;
      end else begin
        diff_q  <= diff_d;
        mode_q  <= mode_in;
        scale_q <= inv_batch_size_times_two_in;
        if (v1_q[c]) grad_q <= grad_d;
      end
    end

    always_comb begin
      grad_d = '0;
      if (!mode_q) begin
        if (prod_sh > G_MAX)      grad_d = D_MAX;
        else if (prod_sh < G_MIN) grad_d = D_MIN;
        else                      grad_d = prod_sh[DATA_W-1:0];
      end else if (diff_q == '0) begin
        grad_d = '0;
      end else if (!diff_q[DW1-1]) begin
        grad_d = half;
      end else if (half == D_MIN) begin
        grad_d = D_MAX;
      end else begin
        grad_d = -half;
      end
    end
  end

  // Widened sums so saturation is a simple overflow-bit test.
  always_comb begin
    sq_sum = '0;
    pop    = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (v1_q[c]) begin
        sq_sum = sq_sum + SUM_W'(sq_flat[c*SQW +: SQW]);
        pop    = pop + PCW'(1);
      end
    end
    acc_sum = loss_clear_in ? sq_sum : SUM_W'(acc_q) + sq_sum;
    acc_d   = (|acc_sum[SUM_W-1:ACC_W]) ? '1 : acc_sum[ACC_W-1:0];
    cnt_sum = loss_clear_in ? CSW'(pop) : CSW'(cnt_q) + CSW'(pop);
    cnt_d   = (|cnt_sum[CSW-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= '0;
      v2_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= valid_in;
      v2_q  <= v1_q;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_out        = v2_q;
  assign loss_sum_out     = acc_q;
  assign sample_count_out = cnt_q;

endmodule
